logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 Port: req_op  input  4  per-requester opcode, bits [2i+1:2i]: 00 AND, 01 OR, 10 NOR, 11 XOR.
REQ-006 Port: req_a  input  2*WIDTH  per-requester operand A, slice [WIDTH*(i+1)-1:WIDTH*i].
REQ-007 Port: req_b  input  2*WIDTH  per-requester operand B, same slicing as req_a.
REQ-008 Port: req_ready  output  2  per-requester accept strobe.
REQ-009 Port: resp_valid  output  2  per-requester result valid; one-hot or zero.
REQ-010 Port: resp_data  output  WIDTH  result shared by both requesters; meaningful only while a resp_valid bit is set.
REQ-011 Port: resp_ack  input  2  per-requester result acknowledge.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.
REQ-013 Port: done_cnt  output  8  count of completed transactions.

Function
REQ-014 The block SHALL share one WIDTH-bit bitwise logic unit between two requesters using a three-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid bit is set, the block SHALL select one winner g and assert only req_ready[g], combinationally, in that cycle.
REQ-016 Winner selection SHALL be round-robin:
- if both requesters are valid, the winner is the requester not equal to last_grant;
- if only one is valid, that requester wins regardless of last_grant.
REQ-017 On the IDLE cycle with req_valid[g] && req_ready[g], the block SHALL register g, req_op[g], req_a[g] and req_b[g], then go to EXEC.
REQ-018 req_ready SHALL be 0 in EXEC and RESP; requests arriving then SHALL wait, with no queueing.
REQ-019 EXEC: the block SHALL compute the selected bitwise operation on all WIDTH bits of the registered operands and load it into the result register, then go to RESP.
- NOR SHALL equal ~(A|B) per bit.
- No carry or width extension.
REQ-020 RESP: the block SHALL hold resp_valid[g]=1 and resp_data=result stable until resp_ack[g]=1.
REQ-021 On a RESP cycle with resp_ack[g]=1, the block SHALL:
- go to IDLE;
- set last_grant=g;
- increment done_cnt.
REQ-022 Minimum latency SHALL be: accept in cycle N, resp_valid asserted in cycle N+2.
REQ-023 Minimum issue interval SHALL be 3 cycles per transaction when the ack is given in the first RESP cycle.
REQ-024 resp_ack on the non-granted bit, and resp_ack in IDLE or EXEC, SHALL be ignored.
REQ-025 done_cnt SHALL wrap from 255 to 0 with no flag.
REQ-026 resp_data SHALL retain the last result after the ack until overwritten in a later EXEC.
REQ-027 A requester dropping req_valid before its handshake SHALL simply not be granted; no state change results.
REQ-028 Simultaneous resp_ack[g] and a new req_valid SHALL NOT be accepted in the same cycle; the new request is considered in the following IDLE cycle.

Reset
REQ-029 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- req_ready, resp_valid and busy to 0;
- result and resp_data to 0;
- done_cnt to 0;
- last_grant to 1, so requester 0 wins the first contention.
REQ-030 Reset asserted mid-transaction SHALL discard that transaction: no response and no done_cnt increment.
REQ-031 After rst_n deasserts, the first request SHALL be evaluated at the next rising clk edge.

Verification
REQ-032 Single request: req0 op=10 (NOR), a=0x0000FFFF, b=0x00FF00FF -> req_ready[0] in cycle N, resp_valid[0] at N+2 with resp_data=0xFF000000; ack -> done_cnt=1.
REQ-033 Contention after reset: both valid, req1 op=11, a=b=0xA5A5A5A5 -> req0 granted first. Then req1 granted, result 0x00000000, done_cnt=2.
REQ-034 Fairness: both held valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-035 Stall: withhold resp_ack[1] for 5 cycles; pulse resp_ack[0] meanwhile -> resp_valid[1] and resp_data stable throughout, req_ready stays 0, state unchanged.
REQ-036 Reset mid-EXEC: drop rst_n for 1 cycle -> all outputs 0 asynchronously, no resp_valid follows, done_cnt=0.
REQ-037 Wrap: complete 256 AND transactions (a=0xFFFFFFFF, b=0x12345678 -> 0x12345678 each) -> done_cnt reads 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter sharing one WIDTH-bit bitwise logic unit (AND/OR/NOR/XOR).
// Round-robin grant in IDLE, one EXEC cycle to compute, RESP held until the
// granted requester acknowledges.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    input  logic [3:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [1:0]         req_ready,
    output logic [1:0]         resp_valid,
    output logic [WIDTH-1:0]   resp_data,
    input  logic [1:0]         resp_ack,
    output logic               busy,
    output logic [7:0]         done_cnt
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q;
    logic             grant_q;
    logic             last_grant_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [1:0]       resp_valid_q;
    logic [7:0]       done_q;

    logic             win;
    logic [1:0]       win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [WIDTH-1:0] alu_out;

    // Round-robin winner: on contention the requester that was not served last wins
    always_comb begin
        win = req_valid[1];
        if (req_valid == 2'b11) begin
            win = ~last_grant_q;
        end
    end

    assign win_op = win ? req_op[3:2]          : req_op[1:0];
    assign win_a  = win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign win_b  = win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    // Ready strobe only for the winner, only in IDLE; gated by rst_n so reset clears it at once
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state_q == StIdle) && (|req_valid)) begin
            req_ready[win] = 1'b1;
        end
    end

    // Shared bitwise logic unit on the registered operands
    always_comb begin
        alu_out = '0;
        unique case (op_q)
            2'b00: alu_out = a_q & b_q;
            2'b01: alu_out = a_q | b_q;
            2'b10: alu_out = ~(a_q | b_q);
            2'b11: alu_out = a_q ^ b_q;
            default: alu_out = '0;
        endcase
    end

    // Control FSM with registered operands, result, response strobe and completion count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            resp_valid_q <= 2'b00;
            done_q       <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        grant_q <= win;
                        op_q    <= win_op;
                        a_q     <= win_a;
                        b_q     <= win_b;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    result_q     <= alu_out;
                    resp_valid_q <= grant_q ? 2'b10 : 2'b01;
                    state_q      <= StResp;
                end
                StResp: begin
                    // Ack on the other bit is ignored; only the granted requester can retire
                    if (resp_ack[grant_q]) begin
                        resp_valid_q <= 2'b00;
                        last_grant_q <= grant_q;
                        done_q       <= done_q + 8'd1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = result_q;
    assign busy       = (state_q != StIdle);
    assign done_cnt   = done_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: scoreboard of expected
// (requester, result) pairs pushed at issue and popped at each response.
module tb_logic_unit_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_ack;
    logic        busy;
    logic [7:0]  done_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          g;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ack   (resp_ack),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Drive one handshake to completion and report what the DUT did
    task automatic serve(input bit drop, output logic [1:0] rdy, output logic [1:0] rv,
                         output logic [31:0] data, output int lat, output int acc_cyc,
                         output bit ok);
        ok = 1'b0; rdy = 2'b00; rv = 2'b00; data = '0; lat = 0; acc_cyc = 0;
        #1;
        for (int i = 0; i < 20 && req_ready == 2'b00; i++) step();
        if (req_ready == 2'b00) return;
        rdy     = req_ready;
        acc_cyc = cyc;
        step();
        if (drop) req_valid = req_valid & ~rdy;
        lat = 1;
        while (resp_valid == 2'b00 && lat < 10) begin
            step();
            lat++;
        end
        if (resp_valid == 2'b00) return;
        rv       = resp_valid;
        data     = resp_data;
        resp_ack = resp_valid;
        step();
        resp_ack = 2'b00;
        ok       = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; req_op = 4'b0; req_a = '0; req_b = '0; resp_ack = 2'b00;
        #3;
        n_checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, required 00 00 0",
                     req_ready, resp_valid, busy);
        end
        n_checks++;
        if (resp_data !== 32'h0 || done_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h cnt=%0d, required 0 0", resp_data, done_cnt);
        end
        req_valid = 2'b00;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [1:0] rdy, rv; logic [31:0] d; int lat, ac; bit ok; exp_t e;
        req_op = 4'b0010; req_a = {32'h0, 32'h0000FFFF}; req_b = {32'h0, 32'h00FF00FF};
        sb.push_back('{0, model(2'b10, 32'h0000FFFF, 32'h00FF00FF)});
        req_valid = 2'b01;
        serve(1'b1, rdy, rv, d, lat, ac, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || rdy !== 2'b01 || rv !== 2'b01 || lat != 2) begin
            n_fail++;
            $display("FAIL single_hs: ok=%0d rdy=%b rv=%b lat=%0d, required 1 01 01 2",
                     ok, rdy, rv, lat);
        end
        n_checks++;
        if (d !== e.d) begin
            n_fail++;
            $display("FAIL single_data: got %h, required %h", d, e.d);
        end
        n_checks++;
        if (done_cnt !== 8'd1 || busy !== 1'b0 || resp_data !== e.d || resp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_after: cnt=%0d busy=%b data=%h rv=%b, required 1 0 %h 00",
                     done_cnt, busy, resp_data, resp_valid, e.d);
        end
    endtask

    task automatic test_contention();
        logic [1:0] rdy, rv; logic [31:0] d; int lat, ac; bit ok; exp_t e;
        do_reset();
        req_op = 4'b1110;
        req_a  = {32'hA5A5A5A5, 32'h0000FFFF};
        req_b  = {32'hA5A5A5A5, 32'h00FF00FF};
        sb.push_back('{0, model(2'b10, 32'h0000FFFF, 32'h00FF00FF)});
        sb.push_back('{1, model(2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5)});
        req_valid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            serve(1'b1, rdy, rv, d, lat, ac, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || rdy !== (2'b01 << e.g) || rv !== (2'b01 << e.g) || d !== e.d) begin
                n_fail++;
                $display("FAIL contention_%0d: ok=%0d rdy=%b rv=%b data=%h, required g=%0d data=%h",
                         k, ok, rdy, rv, d, e.g, e.d);
            end
        end
        n_checks++;
        if (done_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL contention_cnt: got %0d, required 2", done_cnt);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] rdy, rv; logic [31:0] d; int lat, ac, prev; bit ok; exp_t e;
        req_op = 4'b0100;
        req_a  = {32'h0F0F0000, 32'hF0F0F0F0};
        req_b  = {32'h00000F0F, 32'hFF00FF00};
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) sb.push_back('{0, model(2'b00, 32'hF0F0F0F0, 32'hFF00FF00)});
            else            sb.push_back('{1, model(2'b01, 32'h0F0F0000, 32'h00000F0F)});
        end
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            serve(1'b0, rdy, rv, d, lat, ac, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || rdy !== (2'b01 << e.g) || rv !== (2'b01 << e.g) || d !== e.d || lat != 2) begin
                n_fail++;
                $display("FAIL fair_%0d: ok=%0d rdy=%b rv=%b data=%h lat=%0d, required g=%0d data=%h lat=2",
                         k, ok, rdy, rv, d, lat, e.g, e.d);
            end
            if (k > 0) begin
                n_checks++;
                if (ac - prev != 3) begin
                    n_fail++;
                    $display("FAIL fair_interval_%0d: got %0d cycles, required 3", k, ac - prev);
                end
            end
            prev = ac;
        end
        req_valid = 2'b00;
        n_checks++;
        if (done_cnt !== 8'd8) begin
            n_fail++;
            $display("FAIL fair_cnt: got %0d, required 8", done_cnt);
        end
    endtask

    task automatic test_stall();
        exp_t e; int w;
        step();
        req_op = 4'b1100;
        req_a  = {32'h12345678, 32'h0};
        req_b  = {32'hFFFFFFFF, 32'h0};
        sb.push_back('{1, model(2'b11, 32'h12345678, 32'hFFFFFFFF)});
        req_valid = 2'b10;
        #1;
        for (w = 0; w < 20 && req_ready != 2'b10; w++) step();
        step();
        req_valid = 2'b11;
        // Wrong-bit ack during EXEC must be ignored
        resp_ack = 2'b11;
        step();
        resp_ack = 2'b00;
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (resp_valid !== 2'b10 || resp_data !== e.d || req_ready !== 2'b00 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_%0d: rv=%b data=%h rdy=%b busy=%b, required 10 %h 00 1",
                         k, resp_valid, resp_data, req_ready, busy, e.d);
            end
            resp_ack = (k % 2 == 0) ? 2'b01 : 2'b00;
            step();
        end
        resp_ack = 2'b10;
        step();
        resp_ack = 2'b00;
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 2'b00 || done_cnt !== 8'd9 || resp_data !== e.d) begin
            n_fail++;
            $display("FAIL stall_release: busy=%b rv=%b cnt=%0d data=%h, required 0 00 9 %h",
                     busy, resp_valid, done_cnt, resp_data, e.d);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit seen; int w;
        step();
        req_op = 4'b0001; req_a = {32'h0, 32'hFFFF0000}; req_b = {32'h0, 32'h0000FFFF};
        req_valid = 2'b01;
        #1;
        for (w = 0; w < 20 && req_ready != 2'b01; w++) step();
        step();
        req_valid = 2'b00;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_exec: busy=%b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 2'b00 || req_ready !== 2'b00 ||
            resp_data !== 32'h0 || done_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL midrst_async: busy=%b rv=%b rdy=%b data=%h cnt=%0d, required all 0",
                     busy, resp_valid, req_ready, resp_data, done_cnt);
        end
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (resp_valid != 2'b00) seen = 1'b1;
        end
        n_checks++;
        if (seen || done_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_after: resp_seen=%0d cnt=%0d, required 0 0", seen, done_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] rdy, rv; logic [31:0] d; int lat, ac, bad; bit ok; exp_t e;
        req_op = 4'b0000; req_a = {32'h0, 32'hFFFFFFFF}; req_b = {32'h0, 32'h12345678};
        req_valid = 2'b01;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            sb.push_back('{0, model(2'b00, 32'hFFFFFFFF, 32'h12345678)});
            if (k == 255) req_valid = 2'b01;
            serve(k == 255, rdy, rv, d, lat, ac, ok);
            e = sb.pop_front();
            if (!ok || rv !== 2'b01 || d !== e.d) bad++;
            if (k == 254) begin
                n_checks++;
                if (done_cnt !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: got %0d, required 255", done_cnt);
                end
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_data: %0d bad responses, required 0", bad);
        end
        n_checks++;
        if (done_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_cnt: got %0d, required 0", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
